// File: rtl/mem_req_router_if.sv
// Request/response bundle between the CPU data port, the router and the
// seven slaves. The router takes the "slave" view (it is the CPU's target);
// the environment driving CPU requests and slave responses takes "master".
interface mem_req_router_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 32
);
    // CPU side
    logic                   m_valid;
    logic                   m_ready;
    logic                   m_we;
    logic [AW-1:0]          m_addr;
    logic [WIDTH-1:0]       m_wdata;
    logic [WIDTH/8-1:0]     m_wstrb;
    logic                   m_rvalid;
    logic [WIDTH-1:0]       m_rdata;
    logic                   m_err;
    // Slave side (shared request buses, per-slave request and response)
    logic [6:0]             s_req;
    logic                   s_we;
    logic [AW-1:0]          s_addr;
    logic [WIDTH-1:0]       s_wdata;
    logic [WIDTH/8-1:0]     s_wstrb;
    logic [6:0]             s_rvalid;
    logic [7*WIDTH-1:0]     s_rdata;

    modport slave (
        input  m_valid, m_we, m_addr, m_wdata, m_wstrb, s_rvalid, s_rdata,
        output m_ready, m_rvalid, m_rdata, m_err,
               s_req, s_we, s_addr, s_wdata, s_wstrb
    );

    modport master (
        output m_valid, m_we, m_addr, m_wdata, m_wstrb, s_rvalid, s_rdata,
        input  m_ready, m_rvalid, m_rdata, m_err,
               s_req, s_we, s_addr, s_wdata, s_wstrb
    );
endinterface

// File: rtl/mem_req_router.sv
// Single-outstanding memory request router: one CPU data-side request is
// steered to one of seven slaves by a 3-bit address field, and the selected
// slave's response (or an unmapped/timeout error) is returned to the CPU.
module mem_req_router #(
    parameter int WIDTH   = 32,
    parameter int AW      = 32,
    parameter int SEL_LSB = 28,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    mem_req_router_if.slave   bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t               state;
    logic                 we_q;
    logic [AW-1:0]        addr_q;
    logic [WIDTH-1:0]     wdata_q;
    logic [WIDTH/8-1:0]   wstrb_q;
    logic [2:0]           idx_q;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_inc;

    logic                 rvalid_q;
    logic [WIDTH-1:0]     rdata_q;
    logic                 err_q;
    logic [6:0]           req_q;

    logic [2:0]           req_idx;
    logic [6:0]           req_onehot;
    logic                 ack;
    logic [WIDTH-1:0]     ack_data;

    assign req_idx = bus.m_addr[SEL_LSB+2:SEL_LSB];
    assign cnt_inc = cnt + 1'b1;

    // Decode the incoming index and pick the latched slave's ack and data;
    // index 7 matches no slave, so it never produces an ack.
    always_comb begin
        req_onehot = '0;
        ack        = 1'b0;
        ack_data   = '0;
        for (int i = 0; i < 7; i++) begin
            req_onehot[i] = (req_idx == 3'(i));
            if (idx_q == 3'(i)) begin
                ack      = bus.s_rvalid[i];
                ack_data = bus.s_rdata[i*WIDTH +: WIDTH];
            end
        end
    end

    // Transaction FSM with registered request pulse and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            idx_q    <= '0;
            cnt      <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            req_q    <= '0;
        end else begin
            // Response and request outputs are single-cycle pulses.
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            req_q    <= '0;
            case (state)
                IDLE: begin
                    if (bus.m_valid) begin
                        we_q    <= bus.m_we;
                        addr_q  <= bus.m_addr;
                        wdata_q <= bus.m_wdata;
                        wstrb_q <= bus.m_wstrb;
                        idx_q   <= req_idx;
                        if (req_idx == 3'd7) begin
                            // Unmapped: answer immediately, no slave touched.
                            rvalid_q <= 1'b1;
                            err_q    <= 1'b1;
                            state    <= RESP;
                        end else begin
                            req_q <= req_onehot;
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    // s_req is high this cycle; any same-cycle ack is ignored.
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (ack) begin
                        rvalid_q <= 1'b1;
                        rdata_q  <= we_q ? '0 : ack_data;
                        state    <= RESP;
                    end else begin
                        cnt <= cnt_inc;
                        if (cnt_inc == CW'(TIMEOUT)) begin
                            rvalid_q <= 1'b1;
                            err_q    <= 1'b1;
                            state    <= RESP;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.m_ready  = (state == IDLE);
    assign bus.m_rvalid = rvalid_q;
    assign bus.m_rdata  = rdata_q;
    assign bus.m_err    = err_q;
    assign bus.s_req    = req_q;
    assign bus.s_we     = we_q;
    assign bus.s_addr   = addr_q;
    assign bus.s_wdata  = wdata_q;
    assign bus.s_wstrb  = wstrb_q;
endmodule

// File: tb/tb_mem_req_router.sv
// Bench for mem_req_router: directed scenarios followed by randomized
// transactions, each checked against a transaction-level model of the
// router (expected select, response cycle, data and error flag).
module tb_mem_req_router;
    localparam int WIDTH = 32;
    localparam int AW    = 32;
    localparam int SEL   = 28;
    localparam int TO    = 4;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    logic [WIDTH-1:0] sd [7];

    mem_req_router_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

    mem_req_router #(
        .WIDTH(WIDTH), .AW(AW), .SEL_LSB(SEL), .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Absolute run-time guard.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "run did not finish");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_sdata();
        for (int i = 0; i < 7; i++) bus.s_rdata[i*WIDTH +: WIDTH] = sd[i];
    endtask

    // One complete transaction. ack_k is the WAIT cycle (1 = first) on which the
    // addressed slave acks; 0 or > TO means it never acks in time. A different
    // slave nz_slave pulses on WAIT cycle nz_k; issue_pulse makes the addressed
    // slave pulse during the request cycle.
    task automatic run_txn(input logic we, input logic [AW-1:0] addr,
                           input logic [WIDTH-1:0] wdata, input logic [3:0] wstrb,
                           input int ack_k, input logic [WIDTH-1:0] ack_data,
                           input int nz_slave, input int nz_k, input bit issue_pulse);
        int idx;
        int resp_k;
        logic [6:0] exp_req;
        logic [WIDTH-1:0] exp_rdata;
        logic exp_err;
        idx = int'((addr >> SEL) & 32'd7);
        exp_req = '0;
        if (idx < 7) exp_req[idx] = 1'b1;
        // Model: the addressed slave wins if it acks within TO WAIT cycles.
        if (ack_k >= 1 && ack_k <= TO) begin
            resp_k = ack_k; exp_err = 1'b0; exp_rdata = we ? '0 : ack_data;
        end else begin
            resp_k = TO; exp_err = 1'b1; exp_rdata = '0;
        end

        @(negedge clk);
        chk("ready_idle", bus.m_ready, 1'b1);
        bus.m_valid = 1'b1; bus.m_we = we; bus.m_addr = addr;
        bus.m_wdata = wdata; bus.m_wstrb = wstrb;
        @(negedge clk);
        bus.m_valid = 1'b0; bus.m_addr = $urandom; bus.m_wdata = $urandom;
        bus.m_wstrb = 4'($urandom); bus.m_we = ~we;
        if (idx == 7) begin
            chk("unmap_rvalid", bus.m_rvalid, 1'b1);
            chk("unmap_err", bus.m_err, 1'b1);
            chk("unmap_rdata", bus.m_rdata, '0);
            chk("unmap_sreq", bus.s_req, '0);
            chk("unmap_ready_low", bus.m_ready, 1'b0);
            @(negedge clk);
            chk("unmap_ready_back", bus.m_ready, 1'b1);
            chk("unmap_rvalid_low", bus.m_rvalid, 1'b0);
            return;
        end
        chk("issue_sreq", bus.s_req, exp_req);
        chk("issue_saddr", bus.s_addr, addr);
        chk("issue_swe", bus.s_we, we);
        chk("issue_swdata", bus.s_wdata, wdata);
        chk("issue_swstrb", bus.s_wstrb, wstrb);
        chk("issue_ready", bus.m_ready, 1'b0);
        if (issue_pulse) begin
            sd[idx] = ~ack_data; drive_sdata();
            bus.s_rvalid[idx] = 1'b1;
        end
        for (int k = 1; k <= resp_k; k++) begin
            @(negedge clk);
            bus.s_rvalid = '0;
            for (int i = 0; i < 7; i++) sd[i] = $urandom;
            if (k == ack_k) begin
                sd[idx] = ack_data;
                bus.s_rvalid[idx] = 1'b1;
            end
            if (k == nz_k && nz_slave != idx) bus.s_rvalid[nz_slave] = 1'b1;
            drive_sdata();
            chk("wait_sreq", bus.s_req, '0);
            chk("wait_rvalid", bus.m_rvalid, 1'b0);
            chk("wait_swdata", bus.s_wdata, wdata);
            chk("wait_swstrb", bus.s_wstrb, wstrb);
            chk("wait_saddr", bus.s_addr, addr);
        end
        @(negedge clk);
        bus.s_rvalid = '0;
        chk("resp_rvalid", bus.m_rvalid, 1'b1);
        chk("resp_rdata", bus.m_rdata, exp_rdata);
        chk("resp_err", bus.m_err, exp_err);
        chk("resp_ready", bus.m_ready, 1'b0);
        @(negedge clk);
        chk("post_rvalid", bus.m_rvalid, 1'b0);
        chk("post_rdata", bus.m_rdata, '0);
        chk("post_err", bus.m_err, 1'b0);
        chk("post_ready", bus.m_ready, 1'b1);
    endtask

    // Directed scenarios, then randomized traffic, then the summary.
    initial begin
        rst = 1'b1;
        bus.m_valid = 1'b0; bus.m_we = 1'b0; bus.m_addr = '0;
        bus.m_wdata = '0; bus.m_wstrb = '0; bus.s_rvalid = '0;
        for (int i = 0; i < 7; i++) sd[i] = '0;
        drive_sdata();
        repeat (2) @(negedge clk);
        chk("rst_ready", bus.m_ready, 1'b1);
        chk("rst_rvalid", bus.m_rvalid, 1'b0);
        chk("rst_err", bus.m_err, 1'b0);
        chk("rst_rdata", bus.m_rdata, '0);
        chk("rst_sreq", bus.s_req, '0);
        chk("rst_saddr", bus.s_addr, '0);
        rst = 1'b0;

        // Read slave 1, minimum latency.
        run_txn(1'b0, 32'h1000_0040, 32'h0, 4'h0, 1, 32'hCAFE_F00D, 0, 0, 1'b0);
        // Write slave 6, acked on the last allowed WAIT cycle.
        run_txn(1'b1, 32'h6000_0000, 32'h1234_5678, 4'b0011, 4, 32'hDEAD_BEEF, 0, 0, 1'b0);
        // Unmapped index.
        run_txn(1'b0, 32'h7000_0000, 32'h0, 4'h0, 1, 32'h1111_1111, 0, 0, 1'b0);
        // Timeout on slave 3, then a late ack from slave 3 must be ignored.
        run_txn(1'b0, 32'h3000_0100, 32'h0, 4'h0, 0, 32'h0, 0, 0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        bus.s_rvalid[3] = 1'b1;
        @(negedge clk);
        bus.s_rvalid = '0;
        chk("late_ack_rvalid0", bus.m_rvalid, 1'b0);
        @(negedge clk);
        chk("late_ack_rvalid1", bus.m_rvalid, 1'b0);
        // Slave 5 noise on WAIT cycle 1, slave 2 acks on WAIT cycle 3.
        run_txn(1'b0, 32'h2000_0008, 32'h0, 4'h0, 3, 32'hA5A5_0002, 5, 1, 1'b0);
        // Slave 2 acks on the cycle the counter reaches TO: ack wins.
        run_txn(1'b0, 32'h2000_000C, 32'h0, 4'h0, TO, 32'h0BAD_CAFE, 0, 0, 1'b0);
        // Ack pulsed during the request cycle only: must time out.
        run_txn(1'b0, 32'h4000_0000, 32'h0, 4'h0, 0, 32'h5555_AAAA, 0, 0, 1'b1);

        // Reset during WAIT abandons the transaction.
        @(negedge clk);
        bus.m_valid = 1'b1; bus.m_we = 1'b0; bus.m_addr = 32'h4000_0010;
        @(negedge clk);
        bus.m_valid = 1'b0;
        chk("rstw_sreq", bus.s_req, 7'b0010000);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstw_ready", bus.m_ready, 1'b1);
        chk("rstw_rvalid", bus.m_rvalid, 1'b0);
        chk("rstw_err", bus.m_err, 1'b0);
        chk("rstw_rdata", bus.m_rdata, '0);
        chk("rstw_sreq", bus.s_req, '0);
        chk("rstw_saddr", bus.s_addr, '0);
        bus.s_rvalid[4] = 1'b1;
        @(negedge clk);
        bus.s_rvalid = '0;
        chk("rstw_late0", bus.m_rvalid, 1'b0);
        @(negedge clk);
        chk("rstw_late1", bus.m_rvalid, 1'b0);
        run_txn(1'b0, 32'h4000_0010, 32'h0, 4'h0, 2, 32'h7777_0004, 0, 0, 1'b0);

        // Randomized traffic across all indices, ack timings and noise.
        for (int n = 0; n < 40; n++) begin
            logic [AW-1:0] a;
            a = $urandom;
            a[31] = 1'b0;
            a[30:28] = 3'($urandom_range(0, 7));
            run_txn(1'($urandom), a, $urandom, 4'($urandom),
                    int'($urandom_range(0, TO + 2)), $urandom,
                    int'($urandom_range(0, 6)), int'($urandom_range(1, TO)),
                    1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_req_router.md
Name: mem_req_router

Overview:
Routes one CPU data-side memory request to one of seven slave ports, selected by a 3-bit field of the address, and returns the selected slave's response to the CPU. It is the distribution side of the 7-way data-return selection in the datapath: one source fans out to seven destinations. It sits between the MEM stage and the peripheral and memory slaves. Only one transaction is outstanding at a time, and a watchdog counter guards against slaves that never respond.

Parameters:
WIDTH, 32, data width of master and slave data buses
AW, 32, address width
SEL_LSB, 28, bit position of the slave index field; index = m_addr[SEL_LSB+2:SEL_LSB]
TIMEOUT, 255, maximum cycles spent in WAIT before an error response; counter width is $clog2(TIMEOUT+1)

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
m_valid  in  1  master request valid
m_ready  out  1  router can accept a request (high only in IDLE)
m_we  in  1  1 = write, 0 = read
m_addr  in  AW  request address
m_wdata  in  WIDTH  write data
m_wstrb  in  WIDTH/8  byte write strobes
m_rvalid  out  1  one-cycle response pulse
m_rdata  out  WIDTH  read data; 0 on writes and on errors
m_err  out  1  qualifies m_rvalid: unmapped index or timeout
s_req  out  7  one-hot request pulse, bit i = slave i
s_we  out  1  shared, from the latched request
s_addr  out  AW  shared, from the latched request
s_wdata  out  WIDTH  shared, from the latched request
s_wstrb  out  WIDTH/8  shared, from the latched request
s_rvalid  in  7  per-slave response/ack pulse
s_rdata  in  7*WIDTH  flattened; slave i occupies bits [i*WIDTH +: WIDTH]

Behaviour:
- Reset (synchronous, on rst=1 at the clock edge):
  - state = IDLE, m_ready = 1
  - m_rvalid = 0, m_err = 0, m_rdata = 0, s_req = 0
  - latched request registers and timeout counter = 0
  - Reset mid-transaction abandons the transaction. No response is issued, and any later s_rvalid is ignored.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - m_ready = 1.
  - On m_valid=1, latch m_we, m_addr, m_wdata, m_wstrb and idx.
  - If idx = 7, go to RESP with error (unmapped). Otherwise go to ISSUE.
  - m_valid=0: stay in IDLE.
- ISSUE (exactly one cycle):
  - s_req[idx] = 1, all other bits 0.
  - Shared s_* buses carry the latched values. They hold those values from ISSUE through RESP.
  - Clear the counter and go to WAIT.
- WAIT:
  - Sample only s_rvalid[idx]; s_rvalid from any other slave is ignored.
  - On s_rvalid[idx]=1, capture s_rdata slice idx (forced to 0 when the latched we=1), set err = 0, go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT, set err = 1, rdata = 0, go to RESP.
  - If s_rvalid[idx]=1 on the same cycle the counter reaches TIMEOUT, the response wins (err = 0).
- RESP (exactly one cycle):
  - m_rvalid = 1, m_rdata and m_err hold the captured values, m_ready = 0.
  - Next state is IDLE. m_rdata and m_err return to 0 when m_rvalid falls.
- Slaves must not assert s_rvalid in the same cycle as s_req; a pulse in the ISSUE cycle is ignored.
- Minimum latency:
  - Accept at cycle T; s_req at T+1; s_rvalid at T+2; m_rvalid at T+3.
  - Next request can be accepted at T+4.
- Unmapped path: accept at T, m_rvalid with m_err=1 at T+1, no s_req is issued.
- Outputs are registered: m_rvalid, m_rdata, m_err, s_req. m_ready is decoded from state.

Test Plan:
1. Read slave 1: m_addr=0x1000_0040, m_we=0; slave 1 asserts s_rvalid at T+2 with s_rdata[63:32]=0xCAFE_F00D -> s_req=7'b0000010 at T+1 only, s_addr=0x1000_0040, m_rvalid=1 at T+3 with m_rdata=0xCAFE_F00D, m_err=0.
2. Write slave 6: m_addr=0x6000_0000, m_wdata=0x1234_5678, m_wstrb=4'b0011, ack after 5 cycles -> s_req=7'b1000000, s_wdata and s_wstrb stable until ack, m_rvalid=1 with m_rdata=0, m_err=0.
3. Unmapped address: m_addr=0x7000_0000 -> s_req stays 0, m_rvalid=1 and m_err=1 at T+1, m_ready=1 again at T+2.
4. Timeout with TIMEOUT=4, no slave response -> m_rvalid=1, m_err=1, m_rdata=0; then slave 3 pulses s_rvalid three cycles later -> no further m_rvalid.
5. Wrong-slave ack: request to slave 2; slave 5 pulses s_rvalid at T+2, slave 2 pulses at T+4 -> single m_rvalid at T+5 with slave 2's data. Separately, with TIMEOUT=4, slave 2 acks on the cycle the counter reaches 4 -> m_err=0.
6. Reset mid-WAIT: assert rst one cycle after s_req -> next cycle m_ready=1 and all outputs 0; a late slave ack produces no m_rvalid, and the next request completes normally.
